// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: default geometry,
// the RV32 NOP returned while fetch is blocked, and the FSM state encoding.
`timescale 1ns/1ps
package imem_responder_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;  // addi x0,x0,0

  // RUN serves fetches; LOAD accepts loader words; DRAIN is a one-cycle gap
  // before fetch resumes.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Bundles the fetch port and the program-loader port of the responder.
// The master side is the core/loader; the slave side is the responder.
`timescale 1ns/1ps
interface imem_responder_if
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  // Fetch port
  logic [ADDR_W-1:0] rom_addr;
  logic              fetch_en;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              core_hold;

  // Loader port
  logic              ld_start;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output rom_addr, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    input  instr, instr_valid, core_hold, ld_ready, ld_count
  );

  modport slave (
    input  rom_addr, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    output instr, instr_valid, core_hold, ld_ready, ld_count
  );

endinterface

// File: rtl/imem_responder_ram.sv
// Single-write, single synchronous-read RAM, written so that synthesis can
// map it onto a block RAM.
`timescale 1ns/1ps
module imem_ram
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write port: one word per cycle when enabled.
  // NOTE: the array has no reset; resetting it would prevent block-RAM
  // inference, and program contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: registered output that holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: serves one-cycle-latency fetches in RUN and
// accepts a streamed program image in LOAD, stalling the core meanwhile.
`timescale 1ns/1ps
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_ld_count;
  logic              r_instr_valid;
  logic              r_instr_from_ram;  // instr shows RAM data rather than NOP

  logic              w_run;
  logic              w_load;
  logic              w_start;
  logic              w_wr_en;
  logic              w_at_last;
  logic              w_fetch;
  logic [31:0]       w_rdata;

  assign w_run     = (r_state == ST_RUN);
  assign w_load    = (r_state == ST_LOAD);
  assign w_start   = w_run && bus.ld_start;   // ld_start ignored outside RUN
  assign w_wr_en   = w_load && bus.ld_valid;  // ld_ready is exactly w_load
  assign w_at_last = (r_wptr == ADDR_LAST);
  assign w_fetch   = w_run && bus.fetch_en;   // RAM never read while loading

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; the final writable address forces the load to end.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_nxt unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.ld_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_wr_en && (bus.ld_last || w_at_last)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Write pointer and load counter: cleared on load start, never wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_ld_count <= '0;
    end else if (w_start) begin
      r_wptr     <= '0;
      r_ld_count <= '0;
    end else if (w_wr_en) begin
      if (!w_at_last)               r_wptr     <= r_wptr + 1'b1;
      if (r_ld_count != COUNT_MAX)  r_ld_count <= r_ld_count + 1'b1;
    end
  end

  // Fetch response qualifiers; instr falls back to NOP whenever not in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_valid    <= 1'b0;
      r_instr_from_ram <= 1'b0;
    end else begin
      r_instr_valid <= w_fetch;
      if (w_fetch)     r_instr_from_ram <= 1'b1;
      else if (!w_run) r_instr_from_ram <= 1'b0;
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (bus.ld_data),
    .i_re    (w_fetch),
    .i_raddr (bus.rom_addr),
    .o_rdata (w_rdata)
  );

  assign bus.instr       = r_instr_from_ram ? w_rdata : NOP_WORD;
  assign bus.instr_valid = r_instr_valid;
  assign bus.core_hold   = !w_run;
  assign bus.ld_ready    = w_load;
  assign bus.ld_count    = r_ld_count;

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: reset, loading, fetching, forced
// drain at full depth, ignored control pulses and reset during a load.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_responder_if #(.ADDR_W(AW)) bus ();

  imem_responder #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en = 1'b0;
    bus.rom_addr = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
  endtask

  // Fetch a list of addresses back to back and compare each response.
  task automatic fetch_seq(input string name, input logic [AW-1:0] addrs[],
                           input logic [31:0] exp[]);
    bus.fetch_en = 1'b1;
    for (int i = 0; i < addrs.size(); i++) begin
      bus.rom_addr = addrs[i];
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== exp[i]) begin
        n_fail++;
        $display("FAIL %s[%0d]: got valid=%b instr=%h expected valid=1 instr=%h",
                 name, i, bus.instr_valid, bus.instr, exp[i]);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.instr !== NOP || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_instr: got instr=%h valid=%b expected instr=%h valid=0",
               bus.instr, bus.instr_valid, NOP);
    end
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got hold=%b ready=%b expected hold=0 ready=0",
               bus.core_hold, bus.ld_ready);
    end
    n_checks++;
    if (bus.ld_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", bus.ld_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load4();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    n_checks++;
    if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b1 || bus.ld_count !== 9'd0) begin
      n_fail++;
      $display("FAIL load_enter: got hold=%b ready=%b count=%0d expected hold=1 ready=1 count=0",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
    for (int i = 0; i < 4; i++) begin
      bus.fetch_en = 1'b1;
      bus.rom_addr = AW'(i);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hA000_0001 + 32'(i);
      bus.ld_last  = (i == 3);
      tick();
      n_checks++;
      if (bus.instr !== NOP || bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL load_nop[%0d]: got instr=%h valid=%b expected instr=%h valid=0",
                 i, bus.instr, bus.instr_valid, NOP);
      end
      n_checks++;
      if (bus.ld_count !== 9'(i + 1)) begin
        n_fail++;
        $display("FAIL load_count[%0d]: got %0d expected %0d", i, bus.ld_count, i + 1);
      end
      if (i < 3) begin
        n_checks++;
        if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL load_state[%0d]: got hold=%b ready=%b expected hold=1 ready=1",
                   i, bus.core_hold, bus.ld_ready);
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_drain: got hold=%b ready=%b expected hold=1 ready=0",
               bus.core_hold, bus.ld_ready);
    end
    tick();
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_count !== 9'd4) begin
      n_fail++;
      $display("FAIL load_done: got hold=%b ready=%b count=%0d expected hold=0 ready=0 count=4",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
  endtask

  task automatic test_back_to_back();
    fetch_seq("b2b", '{8'd0, 8'd1, 8'd2, 8'd3},
              '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004});
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b0 || bus.instr !== 32'hA000_0004) begin
        n_fail++;
        $display("FAIL hold_instr[%0d]: got valid=%b instr=%h expected valid=0 instr=a0000004",
                 i, bus.instr_valid, bus.instr);
      end
    end
  endtask

  task automatic test_start_ignored();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hB000_0001;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    n_checks++;
    if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b1 || bus.ld_count !== 9'd1) begin
      n_fail++;
      $display("FAIL start_in_load: got hold=%b ready=%b count=%0d expected hold=1 ready=1 count=1",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hB000_0002;
    bus.ld_last  = 1'b1;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_count !== 9'd2) begin
      n_fail++;
      $display("FAIL start_ignored_done: got hold=%b count=%0d expected hold=0 count=2",
               bus.core_hold, bus.ld_count);
    end
    fetch_seq("start_ignored_mem", '{8'd0, 8'd1, 8'd2},
              '{32'hB000_0001, 32'hB000_0002, 32'hA000_0003});
  endtask

  task automatic test_full_load();
    int not_ready = 0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (bus.ld_ready !== 1'b1) not_ready++;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    n_checks++;
    if (not_ready != 0) begin
      n_fail++;
      $display("FAIL full_ready: got %0d cycles not ready expected 0", not_ready);
    end
    n_checks++;
    if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b0 || bus.ld_count !== 9'd256) begin
      n_fail++;
      $display("FAIL full_drain: got hold=%b ready=%b count=%0d expected hold=1 ready=0 count=256",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
    bus.ld_data = 32'hDEAD_BEEF;  // 257th word, must not be taken
    tick();
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_count !== 9'd256) begin
      n_fail++;
      $display("FAIL full_run: got hold=%b ready=%b count=%0d expected hold=0 ready=0 count=256",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
    tick();  // ld_valid still high in RUN
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_count !== 9'd256) begin
      n_fail++;
      $display("FAIL valid_in_run: got hold=%b count=%0d expected hold=0 count=256",
               bus.core_hold, bus.ld_count);
    end
    idle_inputs();
    fetch_seq("full_mem", '{8'd0, 8'd1, 8'd128, 8'd254, 8'd255},
              '{32'hC000_0000, 32'hC000_0001, 32'hC000_0080, 32'hC000_00FE, 32'hC000_00FF});
  endtask

  task automatic test_reset_mid_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hE000_0001 + 32'(i);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'hE000_0003;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.core_hold !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_count !== 9'd0) begin
      n_fail++;
      $display("FAIL midload_reset: got hold=%b ready=%b count=%0d expected hold=0 ready=0 count=0",
               bus.core_hold, bus.ld_ready, bus.ld_count);
    end
    n_checks++;
    if (bus.instr !== NOP || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_instr: got instr=%h valid=%b expected instr=%h valid=0",
               bus.instr, bus.instr_valid, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fetch_seq("midload_mem", '{8'd0, 8'd1, 8'd2, 8'd3},
              '{32'hE000_0001, 32'hE000_0002, 32'hC000_0002, 32'hC000_0003});
  endtask

  initial begin
    test_reset();
    test_load4();
    test_back_to_back();
    test_start_ignored();
    test_full_load();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
